// File: rtl/line_buffer_writer_pkg.sv
// Shared display package: default geometry of the line buffers and the writer FSM encoding.
package line_buffer_writer_pkg;

    localparam int unsigned LINE_LEN_DEFAULT = 100;
    localparam int unsigned ADDR_W_DEFAULT   = 7;
    localparam int unsigned PIX_W_DEFAULT    = 24;

    // Fill state of the writer; StStall waits for the reader to free the pending target.
    typedef enum logic [1:0] {
        StFill1 = 2'd0,
        StFill2 = 2'd1,
        StStall = 2'd2
    } wr_state_e;

    // Buffer selected by a fill state (0 = buffer 1, 1 = buffer 2).
    function automatic logic fill_buf_of(wr_state_e s);
        return (s == StFill2);
    endfunction

endpackage

// File: rtl/line_buffer_writer_if.sv
// Pixel stream, release handshake and both line-buffer write ports of the writer.
interface line_buffer_writer_if
    import line_buffer_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned PIX_W  = PIX_W_DEFAULT
) ();

    logic [PIX_W-1:0]  PixelIn;
    logic              PixelValid;
    logic              PixelReady;
    logic              Flush;
    logic [ADDR_W-1:0] Addr1;
    logic              WE1;
    logic [PIX_W-1:0]  BufferIn1;
    logic [ADDR_W-1:0] Addr2;
    logic              WE2;
    logic [PIX_W-1:0]  BufferIn2;
    logic              Full1;
    logic              Full2;
    logic              Release1;
    logic              Release2;
    logic              ActiveBuf;

    // Writer side.
    modport master (
        input  PixelIn, PixelValid, Flush, Release1, Release2,
        output PixelReady, Addr1, WE1, BufferIn1, Addr2, WE2, BufferIn2,
        output Full1, Full2, ActiveBuf
    );

    // Pixel source / line-buffer reader side.
    modport slave (
        output PixelIn, PixelValid, Flush, Release1, Release2,
        input  PixelReady, Addr1, WE1, BufferIn1, Addr2, WE2, BufferIn2,
        input  Full1, Full2, ActiveBuf
    );

endinterface

// File: rtl/line_buffer_writer.sv
// Ping-pong line buffer writer: fills buffer 1 and 2 alternately, stalls while both are full.
module line_buffer_writer
    import line_buffer_writer_pkg::*;
#(
    parameter int unsigned LINE_LEN = LINE_LEN_DEFAULT,
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned PIX_W    = PIX_W_DEFAULT
) (
    input logic                  Clock,
    input logic                  Reset,
    line_buffer_writer_if.master bus
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LINE_LEN - 1);

    wr_state_e         state_q, state_d;
    logic              target_q, target_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              full1_q, full1_d;
    logic              full2_q, full2_d;
    logic              we1_q, we2_q;
    logic [ADDR_W-1:0] addr1_q, addr2_q;
    logic [PIX_W-1:0]  data1_q, data2_q;
    logic              filling, fill_buf, accept, last;

    // Next state, write count and full flags.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        full1_d  = full1_q;
        full2_d  = full2_q;
        filling  = (state_q != StStall);
        fill_buf = fill_buf_of(state_q);
        accept   = filling && bus.PixelValid && !bus.Flush;
        last     = accept && (count_q == LastAddr);

        // Releasing an empty buffer clears nothing, so a plain clear is enough.
        if (bus.Release1) full1_d = 1'b0;
        if (bus.Release2) full2_d = 1'b0;

        if (filling && bus.Flush) begin
            count_d = '0;
        end else if (accept) begin
            count_d = last ? '0 : count_q + 1'b1;
        end

        unique case (state_q)
            StFill1: begin
                if (last) begin
                    full1_d  = 1'b1;
                    target_d = 1'b1;
                    state_d  = (!full2_q || bus.Release2) ? StFill2 : StStall;
                end
            end
            StFill2: begin
                if (last) begin
                    full2_d  = 1'b1;
                    target_d = 1'b0;
                    state_d  = (!full1_q || bus.Release1) ? StFill1 : StStall;
                end
            end
            StStall: begin
                if (target_q && bus.Release2) state_d = StFill2;
                if (!target_q && bus.Release1) state_d = StFill1;
            end
            default: state_d = StFill1;
        endcase
    end

    // FSM, count and flag registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= StFill1;
            target_q <= 1'b0;
            count_q  <= '0;
            full1_q  <= 1'b0;
            full2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            full1_q  <= full1_d;
            full2_q  <= full2_d;
        end
    end

    // Registered write ports; address and data hold their last written value between writes.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            we1_q   <= 1'b0;
            we2_q   <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            we1_q <= accept && !fill_buf;
            we2_q <= accept && fill_buf;
            if (accept && !fill_buf) begin
                addr1_q <= count_q;
                data1_q <= bus.PixelIn;
            end
            if (accept && fill_buf) begin
                addr2_q <= count_q;
                data2_q <= bus.PixelIn;
            end
        end
    end

    // Outputs; target tracks the fill buffer and holds the pending buffer while stalled.
    always_comb begin
        bus.PixelReady = (state_q != StStall);
        bus.ActiveBuf  = target_q;
        bus.WE1        = we1_q;
        bus.Addr1      = addr1_q;
        bus.BufferIn1  = data1_q;
        bus.WE2        = we2_q;
        bus.Addr2      = addr2_q;
        bus.BufferIn2  = data2_q;
        bus.Full1      = full1_q;
        bus.Full2      = full2_q;
    end

endmodule

// File: tb/tb_line_buffer_writer.sv
// Directed bench for line_buffer_writer: vector table plus multi-line sequences.
module tb_line_buffer_writer;

    logic Clock;
    logic Reset;
    int   n_cmp = 0;
    int   n_err = 0;

    line_buffer_writer_if bus ();

    line_buffer_writer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        v;
        logic        f;
        logic        r1;
        logic        r2;
        logic [23:0] pix;
        logic        we1;
        logic [6:0]  addr1;
        logic [23:0] data1;
        logic        full1;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the edge; pulses drop afterwards.
    task automatic cyc(input logic v, input logic [23:0] p, input logic f,
                       input logic r1, input logic r2);
        bus.PixelValid = v;
        bus.PixelIn    = p;
        bus.Flush      = f;
        bus.Release1   = r1;
        bus.Release2   = r2;
        @(posedge Clock);
        #1;
        bus.PixelValid = 1'b0;
        bus.Flush      = 1'b0;
        bus.Release1   = 1'b0;
        bus.Release2   = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // Push n pixels base+i into buffer (buf2 ? 2 : 1), expecting addresses a0+i.
    task automatic push_line(input string name, input int n, input logic [23:0] base,
                             input logic buf2, input int a0);
        logic [23:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + 24'(i);
            cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
            if (!buf2) begin
                chk({name, " we1"}, 32'(bus.WE1), 32'd1);
                chk({name, " we2"}, 32'(bus.WE2), 32'd0);
                chk({name, " addr1"}, 32'(bus.Addr1), 32'(a0 + i));
                chk({name, " data1"}, 32'(bus.BufferIn1), 32'(d));
            end else begin
                chk({name, " we2"}, 32'(bus.WE2), 32'd1);
                chk({name, " we1"}, 32'(bus.WE1), 32'd0);
                chk({name, " addr2"}, 32'(bus.Addr2), 32'(a0 + i));
                chk({name, " data2"}, 32'(bus.BufferIn2), 32'(d));
            end
        end
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, " ready"}, 32'(bus.PixelReady), 32'd1);
        chk({name, " we1"}, 32'(bus.WE1), 32'd0);
        chk({name, " we2"}, 32'(bus.WE2), 32'd0);
        chk({name, " addr1"}, 32'(bus.Addr1), 32'd0);
        chk({name, " addr2"}, 32'(bus.Addr2), 32'd0);
        chk({name, " data1"}, 32'(bus.BufferIn1), 32'd0);
        chk({name, " data2"}, 32'(bus.BufferIn2), 32'd0);
        chk({name, " full1"}, 32'(bus.Full1), 32'd0);
        chk({name, " full2"}, 32'(bus.Full2), 32'd0);
        chk({name, " active"}, 32'(bus.ActiveBuf), 32'd0);
    endtask

    initial begin
        int pulses;
        bus.PixelValid = 1'b0;
        bus.PixelIn    = '0;
        bus.Flush      = 1'b0;
        bus.Release1   = 1'b0;
        bus.Release2   = 1'b0;
        Reset          = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        chk_reset_values("reset");
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Short directed vectors on buffer 1: gaps, flush, releases of empty buffers.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hA00001, 1'b1, 7'd0, 24'hA00001, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 7'd0, 24'h000000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hA00002, 1'b1, 7'd1, 24'hA00002, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'hA00003, 1'b0, 7'd0, 24'h000000, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hA00004, 1'b1, 7'd0, 24'hA00004, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'hA00005, 1'b1, 7'd1, 24'hA00005, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 7'd0, 24'h000000, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hA00007, 1'b1, 7'd0, 24'hA00007, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 24'hA00008, 1'b1, 7'd1, 24'hA00008, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, 1'b0, 7'd0, 24'h000000, 1'b0};
        for (int k = 0; k < 10; k++) begin
            cyc(vecs[k].v, vecs[k].pix, vecs[k].f, vecs[k].r1, vecs[k].r2);
            chk($sformatf("vec%0d we1", k), 32'(bus.WE1), 32'(vecs[k].we1));
            chk($sformatf("vec%0d we2", k), 32'(bus.WE2), 32'd0);
            chk($sformatf("vec%0d ready", k), 32'(bus.PixelReady), 32'd1);
            chk($sformatf("vec%0d active", k), 32'(bus.ActiveBuf), 32'd0);
            chk($sformatf("vec%0d full1", k), 32'(bus.Full1), 32'(vecs[k].full1));
            chk($sformatf("vec%0d full2", k), 32'(bus.Full2), 32'd0);
            if (vecs[k].we1) begin
                chk($sformatf("vec%0d addr1", k), 32'(bus.Addr1), 32'(vecs[k].addr1));
                chk($sformatf("vec%0d data1", k), 32'(bus.BufferIn1), 32'(vecs[k].data1));
            end
        end

        // One full line into buffer 1.
        do_reset();
        push_line("line1", 100, 24'h000000, 1'b0, 0);
        chk("line1 full1", 32'(bus.Full1), 32'd1);
        chk("line1 full2", 32'(bus.Full2), 32'd0);
        chk("line1 active", 32'(bus.ActiveBuf), 32'd1);
        chk("line1 ready", 32'(bus.PixelReady), 32'd1);

        // Second line into buffer 2 with no release: both full, stall.
        push_line("line2", 100, 24'h100000, 1'b1, 0);
        chk("stall full2", 32'(bus.Full2), 32'd1);
        chk("stall ready", 32'(bus.PixelReady), 32'd0);
        chk("stall active", 32'(bus.ActiveBuf), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 24'hFFFFFF, (i == 2), 1'b0, 1'b0);
            chk("stall we1", 32'(bus.WE1), 32'd0);
            chk("stall we2", 32'(bus.WE2), 32'd0);
            chk("stall hold ready", 32'(bus.PixelReady), 32'd0);
        end
        cyc(1'b1, 24'hFFFFFF, 1'b0, 1'b1, 1'b0);
        chk("release1 ready", 32'(bus.PixelReady), 32'd1);
        chk("release1 full1", 32'(bus.Full1), 32'd0);
        chk("release1 full2", 32'(bus.Full2), 32'd1);
        chk("release1 we1", 32'(bus.WE1), 32'd0);
        chk("release1 active", 32'(bus.ActiveBuf), 32'd0);
        push_line("after stall", 1, 24'h123456, 1'b0, 0);

        // Buffer 2 completes in the same cycle buffer 1 is released: no stall.
        cyc(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        chk("release2 full2", 32'(bus.Full2), 32'd0);
        push_line("fill1 rest", 99, 24'h200001, 1'b0, 1);
        chk("fill1 rest full1", 32'(bus.Full1), 32'd1);
        chk("fill1 rest active", 32'(bus.ActiveBuf), 32'd1);
        push_line("fill2", 99, 24'h300000, 1'b1, 0);
        cyc(1'b1, 24'h3000AA, 1'b0, 1'b1, 1'b0);
        chk("same-cycle we2", 32'(bus.WE2), 32'd1);
        chk("same-cycle addr2", 32'(bus.Addr2), 32'd99);
        chk("same-cycle ready", 32'(bus.PixelReady), 32'd1);
        chk("same-cycle full1", 32'(bus.Full1), 32'd0);
        chk("same-cycle full2", 32'(bus.Full2), 32'd1);
        chk("same-cycle active", 32'(bus.ActiveBuf), 32'd0);
        push_line("after same-cycle", 1, 24'h400000, 1'b0, 0);

        // Asynchronous reset mid-line (count 50, Full2 set), checked before any edge.
        push_line("to count 50", 49, 24'h500001, 1'b0, 1);
        chk("pre-reset full2", 32'(bus.Full2), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk_reset_values("async reset");
        Reset = 1'b0;
        push_line("post reset", 1, 24'h600000, 1'b0, 0);

        // Flush after 37 pixels restarts buffer 1 at address 0.
        do_reset();
        push_line("pre flush", 37, 24'h700000, 1'b0, 0);
        cyc(1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
        chk("flush we1", 32'(bus.WE1), 32'd0);
        chk("flush active", 32'(bus.ActiveBuf), 32'd0);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 24'h800000 + 24'(i), 1'b0, 1'b0, 1'b0);
            chk("post flush addr1", 32'(bus.Addr1), 32'(i));
            chk("post flush full1", 32'(bus.Full1), 32'(i == 99));
        end

        // Valid every other cycle over a full line.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            cyc((i % 2) == 0, 24'h000100 + 24'(i / 2), 1'b0, 1'b0, 1'b0);
            chk("toggle we2", 32'(bus.WE2), 32'd0);
            if (bus.WE1 === 1'b1) begin
                chk("toggle addr1", 32'(bus.Addr1), 32'(pulses));
                chk("toggle data1", 32'(bus.BufferIn1), 32'h100 + 32'(pulses));
                pulses++;
            end
        end
        chk("toggle pulses", 32'(pulses), 32'd100);
        chk("toggle full1", 32'(bus.Full1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/line_buffer_writer.md
LINE_BUFFER_WRITER -- requirements
Module: line_buffer_writer

Interface
REQ-001 SHALL have parameter LINE_LEN, default 100: pixels per line, which is also the buffer depth.
REQ-002 SHALL have parameter ADDR_W, default 7: address width; 2^ADDR_W >= LINE_LEN.
REQ-003 SHALL have parameter PIX_W, default 24: pixel width, RGB 8:8:8, R in [23:16].
REQ-004 Clock  input  1  single clock; all state changes on posedge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 PixelIn  input  PIX_W  incoming pixel data.
REQ-007 PixelValid  input  1  PixelIn valid this cycle.
REQ-008 PixelReady  output  1  block can accept a pixel this cycle.
REQ-009 Flush  input  1  abandon the partially written line.
REQ-010 Addr1 / WE1 / BufferIn1  output  ADDR_W / 1 / PIX_W  write port to line buffer 1.
REQ-011 Addr2 / WE2 / BufferIn2  output  ADDR_W / 1 / PIX_W  write port to line buffer 2.
REQ-012 Full1, Full2  output  1  buffer holds a complete line not yet released by the reader.
REQ-013 Release1, Release2  input  1  single-cycle pulse from the reader: buffer consumed.
REQ-014 ActiveBuf  output  1  buffer currently being filled (0 = buffer 1, 1 = buffer 2).

Function
REQ-015 Accept SHALL occur when PixelValid && PixelReady at a posedge.
REQ-016 An accept SHALL drive WEx=1, Addrx=write count, BufferInx=PixelIn of the active buffer, registered, one cycle after the accept.
REQ-017 WE of the inactive buffer SHALL be 0 at all times; a WE SHALL be 0 in every cycle not following an accept.
REQ-018 Write count SHALL increment per accept, from 0 to LINE_LEN-1.
REQ-019 On the accept of pixel LINE_LEN-1, count SHALL wrap to 0 and Fullx of the active buffer SHALL set one cycle after the accept, coincident with the last WE.
REQ-020 FSM states: FILL1, FILL2, STALL.
REQ-021 Line completion in FILLx SHALL move to FILL of the other buffer if its Full is 0 (or is released in the same cycle); otherwise it SHALL move to STALL with the pending target recorded.
REQ-022 STALL SHALL go to FILL(target) on the cycle after Release(target).
REQ-023 PixelReady SHALL be 0 in STALL and 1 in FILL1/FILL2, decoded from the state register only.
REQ-024 Releasex SHALL clear Fullx on the next edge; Releasex while Fullx=0 SHALL be ignored.
REQ-025 Release1 and Release2 together SHALL clear both flags.
REQ-026 Flush SHALL reset the count to 0, leave the buffer selection and Full flags unchanged, and suppress any accept in the same cycle.
REQ-027 Flush in STALL SHALL have no effect.
REQ-028 ActiveBuf SHALL equal the buffer of the current FILL state; in STALL it SHALL equal the pending target.

Reset
REQ-029 Reset SHALL asynchronously force: state FILL1, count 0, Full1=Full2=0, WE1=WE2=0, Addr1=Addr2=0, BufferIn1=BufferIn2=0, ActiveBuf=0.
REQ-030 After Reset deasserts, PixelReady SHALL be 1.
REQ-031 Reset mid-line SHALL discard the partial line; the next accepted pixel SHALL be written to buffer 1, address 0.

Structure
REQ-032 LINE_LEN, ADDR_W, PIX_W defaults and the FSM state encoding SHALL live in the shared display package.
REQ-033 The block SHALL be a single module with no sub-modules; each buffer port connects directly to an existing line-buffer instance.

Verification
REQ-034 Reset, then 100 consecutive valid pixels 0x000000..0x000063 -> WE1 pulses at Addr1 0..99 with matching data, Full1=1 after the 100th write, ActiveBuf=1, WE2 never asserted.
REQ-035 Fill both buffers (200 pixels) without release -> PixelReady=0 after the 200th accept; PixelValid held high with 0xFFFFFF produces no WE; Release1 pulse -> PixelReady=1 next cycle, next pixel written to Addr1=0.
REQ-036 Completion of buffer 2 in the same cycle as Release1 -> no STALL cycle, PixelReady stays 1, next write goes to buffer 1, address 0.
REQ-037 Flush after 37 pixels in buffer 1 -> next pixel written to Addr1=0; Full1 stays 0 until 100 further pixels.
REQ-038 Reset asserted mid-line (count 50, Full2=1) -> all outputs take reset values immediately, without a clock edge; Full2=0; the first post-reset pixel goes to Addr1=0.
REQ-039 PixelValid toggled every other cycle over a full line -> exactly 100 WE1 pulses, addresses contiguous, no duplicated or skipped data.
